// File: rtl/ternary_trit_deserializer.sv
// Rebuilds unsigned binary words from an MSB-first stream of 2-bit trit codes.
// Holds each completed word until the downstream side accepts it.
module ternary_trit_deserializer #(
    parameter int NTRITS = 5,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_t1,
    input  logic             in_t0,
    input  logic             frame_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);
    localparam int CNT_W = $clog2(NTRITS + 1);

    function automatic longint unsigned pow3(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 3;
        return p;
    endfunction

    localparam longint unsigned TRIT_SPAN = pow3(NTRITS);
    localparam bit FITS = (OUT_W >= 64) || (TRIT_SPAN <= (64'd1 << OUT_W));

    generate
        if (NTRITS < 1 || NTRITS > 20 || !FITS) begin : g_param_chk
            $error("ternary_trit_deserializer: NTRITS out of 1..20 or 3**NTRITS exceeds 2**OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
    } word_t;

    state_t           state, state_nxt;
    word_t            word, word_nxt;
    logic             illegal;
    logic [1:0]       trit;
    logic [CNT_W-1:0] cnt_inc;

    // Code 11 still occupies a trit slot but contributes nothing to the value.
    assign illegal = in_t1 & in_t0;
    assign trit    = illegal ? 2'd0 : {in_t1, in_t0};
    assign cnt_inc = word.cnt + 1'b1;

    assign in_ready  = rst_n & (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_data  = out_valid ? word.acc : '0;
    assign out_err   = out_valid & word.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
        end
    end

    // IDLE and ACC share one path: the word is all-zero in IDLE, so acc*3+trit
    // and cnt+1 give the first-trit values directly.
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        case (state)
            IDLE, ACC: begin
                if (frame_clr) begin
                    state_nxt = IDLE;
                    word_nxt  = '0;
                end else if (in_valid) begin
                    word_nxt.acc = (word.acc << 1) + word.acc + OUT_W'(trit);
                    word_nxt.err = word.err | illegal;
                    word_nxt.cnt = cnt_inc;
                    state_nxt    = (cnt_inc == CNT_W'(NTRITS)) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    word_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                word_nxt  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_ternary_trit_deserializer.sv
// Directed bench for ternary_trit_deserializer at NTRITS=5, OUT_W=8.
module tb_ternary_trit_deserializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_t1 = 1'b0;
    logic       in_t0 = 1'b0;
    logic       frame_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_err;
    int         n_pass = 0;
    int         n_total = 0;

    ternary_trit_deserializer #(.NTRITS(5), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_t1(in_t1), .in_t0(in_t0), .frame_clr(frame_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Present one code for one edge; leaves in_valid high for back-to-back use.
    task automatic drive_trit(input logic [1:0] c);
        in_valid = 1'b1;
        {in_t1, in_t0} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [4:0][1:0] w);
        for (int i = 4; i >= 0; i--) drive_trit(w[i]);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        {in_t1, in_t0} = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d exp 0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b exp 0", in_ready); else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b exp 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_word();
        out_ready = 1'b1;
        drive_trit(2'b01);
        drive_trit(2'b00);
        drive_trit(2'b10);
        drive_trit(2'b01);
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b exp 0", out_valid); else n_pass++;
        drive_trit(2'b10);
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd104) $display("FAIL basic_data: got %0d exp 104", out_data); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL basic_err: got %b exp 0", out_err); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL basic_hold_in_ready: got %b exp 0", in_ready); else n_pass++;
        idle_cycle();
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_extremes();
        send_word({2'b10, 2'b10, 2'b10, 2'b10, 2'b10});
        n_total++; if (out_data !== 8'd242) $display("FAIL all2_data: got %0d exp 242", out_data); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL all2_err: got %b exp 0", out_err); else n_pass++;
        idle_cycle();
        send_word({2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        n_total++; if (out_valid !== 1'b1) $display("FAIL all0_valid: got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL all0_data: got %0d exp 0", out_data); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL all0_err: got %b exp 0", out_err); else n_pass++;
        idle_cycle();
    endtask

    task automatic test_illegal();
        send_word({2'b10, 2'b11, 2'b01, 2'b00, 2'b00});
        n_total++; if (out_valid !== 1'b1) $display("FAIL illegal_valid: got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd171) $display("FAIL illegal_data: got %0d exp 171", out_data); else n_pass++;
        n_total++; if (out_err !== 1'b1) $display("FAIL illegal_err: got %b exp 1", out_err); else n_pass++;
        idle_cycle();
        send_word({2'b00, 2'b00, 2'b00, 2'b00, 2'b01});
        n_total++; if (out_data !== 8'd1) $display("FAIL clean_after_err_data: got %0d exp 1", out_data); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL clean_after_err_err: got %b exp 0", out_err); else n_pass++;
        idle_cycle();
    endtask

    task automatic test_back_to_back_backpressure();
        int bad;
        out_ready = 1'b0;
        send_word({2'b01, 2'b01, 2'b01, 2'b01, 2'b01});
        // Next word's first trit waits on the bus; a frame_clr here must be ignored.
        in_valid = 1'b1;
        {in_t1, in_t0} = 2'b10;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            frame_clr = (i == 4);
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd121 || out_err !== 1'b0) bad++;
        end
        frame_clr = 1'b0;
        n_total++; if (bad != 0) $display("FAIL stall_stable: %0d bad cycles exp 0 (data %0d exp 121)", bad, out_data); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL stall_release_valid: got %b exp 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_in_ready: got %b exp 1", in_ready); else n_pass++;
        drive_trit(2'b10);
        drive_trit(2'b00);
        drive_trit(2'b00);
        drive_trit(2'b00);
        drive_trit(2'b01);
        in_valid = 1'b0;
        n_total++; if (out_data !== 8'd163) $display("FAIL after_stall_data: got %0d exp 163", out_data); else n_pass++;
        idle_cycle();
    endtask

    task automatic test_frame_clr();
        drive_trit(2'b10);
        drive_trit(2'b10);
        drive_trit(2'b10);
        frame_clr = 1'b1;
        drive_trit(2'b10);
        frame_clr = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL clr_valid: got %b exp 0", out_valid); else n_pass++;
        send_word({2'b00, 2'b00, 2'b00, 2'b01, 2'b01});
        n_total++; if (out_valid !== 1'b1) $display("FAIL clr_word_valid: got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd4) $display("FAIL clr_word_data: got %0d exp 4", out_data); else n_pass++;
        idle_cycle();
    endtask

    task automatic test_reset_mid_word();
        drive_trit(2'b10);
        drive_trit(2'b10);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b exp 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word({2'b00, 2'b00, 2'b00, 2'b00, 2'b10});
        n_total++; if (out_data !== 8'd2) $display("FAIL midrst_word_data: got %0d exp 2", out_data); else n_pass++;
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_extremes();
        test_illegal();
        test_back_to_back_backpressure();
        test_frame_clr();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
